// File: rtl/cache_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | arbiter_types: state and grant encodings shared by the cache arbiter.       |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package arbiter_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | cache_arbiter_if: I-cache, D-cache and physical-memory signals of the        |
// | arbiter. master = arbiter view, slave = environment view.  Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cache_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/cache_arbiter.sv
// +----------------------------------------------------------------------------+
// | cache_arbiter: round-robin arbiter sharing one physical memory port         |
// | between the I-cache and D-cache.  Rev 1.0                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  wire              clk,
    input  wire              reset,
    cache_arbiter_if.master  bus
);

    state_e state_q, state_d;
    grant_e last_grant_q, last_grant_d;

    logic              w_pmem_read;
    logic              w_pmem_write;
    logic [ADDR_W-1:0] w_pmem_address;
    logic [LINE_W-1:0] w_pmem_wdata;
    logic              w_i_resp;
    logic              w_d_resp;
    logic              w_d_req;

    assign w_d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        w_pmem_read    = 1'b0;
        w_pmem_write   = 1'b0;
        w_pmem_address = '0;
        w_pmem_wdata   = bus.d_wdata;
        w_i_resp       = 1'b0;
        w_d_resp       = 1'b0;

        case (state_q)
            IDLE: begin
                // Under contention the side that did not win last time goes next.
                if (bus.i_read && w_d_req) begin
                    if (last_grant_q == GRANT_I) begin
                        state_d      = SERVE_D;
                        last_grant_d = GRANT_D;
                    end else begin
                        state_d      = SERVE_I;
                        last_grant_d = GRANT_I;
                    end
                end else if (bus.i_read) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                end else if (w_d_req) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                end
            end

            SERVE_I: begin
                w_pmem_read    = bus.i_read;
                w_pmem_address = bus.i_address;
                w_i_resp       = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end

            SERVE_D: begin
                // A simultaneous read and write is illegal; the write takes priority.
                w_pmem_read    = bus.d_read & ~bus.d_write;
                w_pmem_write   = bus.d_write;
                w_pmem_address = bus.d_address;
                w_d_resp       = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pmem_read    = w_pmem_read;
    assign bus.pmem_write   = w_pmem_write;
    assign bus.pmem_address = w_pmem_address;
    assign bus.pmem_wdata   = w_pmem_wdata;
    assign bus.i_resp       = w_i_resp;
    assign bus.d_resp       = w_d_resp;
    assign bus.i_rdata      = bus.pmem_rdata;
    assign bus.d_rdata      = bus.pmem_rdata;

endmodule

`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning physical address width.
REQ-003 SHALL have clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have i_read  input  1  I-cache line-fill request.
REQ-006 SHALL have i_address  input  ADDR_W  I-cache line address.
REQ-007 SHALL have i_rdata  output  LINE_W  line returned to I-cache.
REQ-008 SHALL have i_resp  output  1  I-cache transaction complete.
REQ-009 SHALL have d_read, d_write  input  1 each  D-cache fill / writeback request.
REQ-010 SHALL have d_address  input  ADDR_W  D-cache line address.
REQ-011 SHALL have d_wdata  input  LINE_W  D-cache writeback line.
REQ-012 SHALL have d_rdata  output  LINE_W  line returned to D-cache.
REQ-013 SHALL have d_resp  output  1  D-cache transaction complete.
REQ-014 SHALL have pmem_read, pmem_write  output  1 each  physical memory command.
REQ-015 SHALL have pmem_address  output  ADDR_W; pmem_wdata  output  LINE_W.
REQ-016 SHALL have pmem_rdata  input  LINE_W; pmem_resp  input  1  memory done.

Function
REQ-017 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-018 IDLE: all pmem_* commands 0, i_resp = d_resp = 0; IDLE lasts at least one cycle between grants.
REQ-019 IDLE, only i_read high -> next state SERVE_I; only d_read or d_write high -> SERVE_D; none -> IDLE.
REQ-020 IDLE, both requesters pending -> grant the requester NOT in last_grant register (round-robin); last_grant resets to I, so first contention grants D.
REQ-021 last_grant SHALL update to the granted side on each IDLE->SERVE_x transition.
REQ-022 SERVE_I: pmem_read = i_read, pmem_write = 0, pmem_address = i_address; pmem_wdata = d_wdata (don't-care).
REQ-023 SERVE_D: pmem_read = d_read & ~d_write, pmem_write = d_write, pmem_address = d_address, pmem_wdata = d_wdata; d_read & d_write together is a protocol violation, write wins.
REQ-024 i_rdata and d_rdata SHALL both equal pmem_rdata combinationally at all times.
REQ-025 i_resp = pmem_resp in SERVE_I only; d_resp = pmem_resp in SERVE_D only; same cycle, no added latency.
REQ-026 SERVE_x with pmem_resp = 1 -> IDLE next cycle; without pmem_resp -> remain SERVE_x indefinitely (no timeout).
REQ-027 Requesters SHALL hold address/data/command stable until resp and deassert the command the cycle after resp; arbiter does not re-check the command mid-service.
REQ-028 Arbitration latency: request seen in IDLE at cycle N -> pmem command asserted at cycle N+1.
REQ-029 pmem_resp received while IDLE SHALL be ignored (no resp forwarded, no state change).
REQ-030 New requests arriving during SERVE_x SHALL wait; the pending side is guaranteed the next grant.

Reset
REQ-031 reset high at any edge -> state IDLE, last_grant = I; in-flight transaction abandoned, no resp forwarded afterward.
REQ-032 While reset is high, all command and resp outputs SHALL be 0 from the cycle after reset assertion.

Structure
REQ-033 Shared package arbiter_types SHALL hold the state enum (IDLE, SERVE_I, SERVE_D) and the grant enum (GRANT_I, GRANT_D).
REQ-034 Single module, no sub-modules; one state register, one last_grant register, combinational output/next-state logic.

Verification
REQ-035 Lone I fill: i_read=1, i_address=0x0000_0060, memory resp after 5 cycles -> pmem_read=1 with 0x0000_0060 from cycle 1; i_resp pulses once with i_rdata = pmem_rdata; d_resp stays 0.
REQ-036 Lone D writeback: d_write=1, d_address=0x0000_1000, d_wdata=all 0xA5 -> pmem_write=1 with same address/data; d_resp single pulse; returns to IDLE.
REQ-037 Contention after reset: i_read and d_read high same cycle -> D served first, then I; next simultaneous contention -> D again, alternating only under contention.
REQ-038 Request during service: d_read arrives while SERVE_I -> D granted exactly 2 cycles after i_resp (IDLE + grant), and pmem commands stay 0 during the IDLE cycle.
REQ-039 Reset mid-service: assert reset in SERVE_D before pmem_resp, then pulse pmem_resp -> no d_resp, state IDLE, pmem_* = 0.
REQ-040 Spurious pmem_resp in IDLE -> i_resp = d_resp = 0, state unchanged.
